frog_mem: RTL and testbench



---
 rtl/frog_pkg.sv | 20 ++
 rtl/frog_mem_array.sv | 36 +++
 rtl/frog_mem.sv | 104 ++++++++++
 tb/tb_frog_mem.sv | 454 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/frog_pkg.sv
// Shared frog definitions: default widths, write-FSM states and CPU opcodes.
package frog_pkg;

    localparam int unsigned DEF_ADDR_W = 7;
    localparam int unsigned DEF_DATA_W = 4;

    // Opcode nibbles, shared with the CPU and the bench
    localparam logic [3:0] OP_LDA = 4'h1;
    localparam logic [3:0] OP_LDB = 4'h2;
    localparam logic [3:0] OP_STA = 4'h3;
    localparam logic [3:0] OP_ADD = 4'h4;
    localparam logic [3:0] OP_JMP = 4'h5;
    localparam logic [3:0] OP_NOP = 4'h8;

    typedef enum logic {
        W_IDLE = 1'b0,
        W_DATA = 1'b1
    } wstate_t;

endpackage

// File: rtl/frog_mem_array.sv
// Register file with async clear, one synchronous write port and two combinational read ports.
module frog_mem_array
    import frog_pkg::*;
#(
    parameter int unsigned ADDR_W = DEF_ADDR_W,
    parameter int unsigned DATA_W = DEF_DATA_W
) (
    input  logic              clk,
    input  logic              rst_p,
    input  logic              we,
    input  logic [ADDR_W-1:0] waddr,
    input  logic [DATA_W-1:0] wdata,
    input  logic [ADDR_W-1:0] raddr_a,
    output logic [DATA_W-1:0] rdata_a,
    input  logic [ADDR_W-1:0] raddr_b,
    output logic [DATA_W-1:0] rdata_b
);

    localparam int unsigned DEPTH = 2 ** ADDR_W;

    logic [DATA_W-1:0] mem [DEPTH];

    always_ff @(posedge clk or posedge rst_p) begin
        if (rst_p) begin
            for (int unsigned i = 0; i < DEPTH; i++) begin
                mem[ADDR_W'(i)] <= '0;
            end
        end else if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata_a = mem[raddr_a];
    assign rdata_b = mem[raddr_b];

endmodule

// File: rtl/frog_mem.sv
// Memory responder on the frog CPU bus: zero-latency reads, two-beat CPU writes, host preload port.
module frog_mem
    import frog_pkg::*;
#(
    parameter int unsigned ADDR_W   = DEF_ADDR_W,
    parameter int unsigned DATA_W   = DEF_DATA_W,
    parameter logic [3:0]  NOP_WORD = OP_NOP
) (
    input  logic              clk,
    input  logic              rst_p,
    input  logic [ADDR_W-1:0] cpu_bus,
    input  logic              cpu_wcyc,
    output logic [DATA_W-1:0] cpu_data,
    input  logic              host_sel,
    input  logic              host_we,
    input  logic [ADDR_W-1:0] host_addr,
    input  logic [DATA_W-1:0] host_wdata,
    output logic [DATA_W-1:0] host_rdata,
    output logic [7:0]        wr_count,
    output logic              proto_err,
    output logic              wr_phase
);

    wstate_t           state;
    logic [ADDR_W-1:0] waddr;

    logic              cpu_we_c;
    logic              mem_we_c;
    logic [ADDR_W-1:0] mem_waddr_c;
    logic [DATA_W-1:0] mem_wdata_c;
    logic [DATA_W-1:0] cpu_rdata_c;

    // Data beat commits only while the CPU still owns memory
    assign cpu_we_c = (state == W_DATA) && cpu_wcyc && !host_sel;

    // Single write port: host owns it whenever host_sel is high
    always_comb begin
        mem_we_c    = cpu_we_c;
        mem_waddr_c = waddr;
        mem_wdata_c = cpu_bus[DATA_W-1:0];
        if (host_sel) begin
            mem_we_c    = host_we;
            mem_waddr_c = host_addr;
            mem_wdata_c = host_wdata;
        end
    end

    frog_mem_array #(
        .ADDR_W (ADDR_W),
        .DATA_W (DATA_W)
    ) u_array (
        .clk     (clk),
        .rst_p   (rst_p),
        .we      (mem_we_c),
        .waddr   (mem_waddr_c),
        .wdata   (mem_wdata_c),
        .raddr_a (cpu_bus),
        .rdata_a (cpu_rdata_c),
        .raddr_b (host_addr),
        .rdata_b (host_rdata)
    );

    assign cpu_data = host_sel ? DATA_W'(NOP_WORD) : cpu_rdata_c;

    // Write FSM: address beat then data beat; status registers alongside
    always_ff @(posedge clk or posedge rst_p) begin
        if (rst_p) begin
            state     <= W_IDLE;
            waddr     <= '0;
            wr_count  <= '0;
            proto_err <= 1'b0;
            wr_phase  <= 1'b0;
        end else begin
            case (state)
                W_IDLE: begin
                    if (cpu_wcyc && !host_sel) begin
                        waddr    <= cpu_bus;
                        state    <= W_DATA;
                        wr_phase <= 1'b1;
                    end
                end
                W_DATA: begin
                    state    <= W_IDLE;
                    wr_phase <= 1'b0;
                    if (!host_sel) begin
                        if (!cpu_wcyc) begin
                            proto_err <= 1'b1;
                        end else begin
                            wr_count <= wr_count + 8'd1;
                            if (cpu_bus[ADDR_W-1:DATA_W] != '0) begin
                                proto_err <= 1'b1;
                            end
                        end
                    end
                end
                default: begin
                    state    <= W_IDLE;
                    wr_phase <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_frog_mem.sv
// Scoreboard bench for frog_mem: expected read nibbles are queued at drive time, popped at sample time.
module tb_frog_mem;
    import frog_pkg::*;

    logic       clk = 1'b0;
    logic       rst_p;
    logic [6:0] cpu_bus;
    logic       cpu_wcyc;
    logic [3:0] cpu_data;
    logic       host_sel;
    logic       host_we;
    logic [6:0] host_addr;
    logic [3:0] host_wdata;
    logic [3:0] host_rdata;
    logic [7:0] wr_count;
    logic       proto_err;
    logic       wr_phase;

    frog_mem dut (
        .clk        (clk),
        .rst_p      (rst_p),
        .cpu_bus    (cpu_bus),
        .cpu_wcyc   (cpu_wcyc),
        .cpu_data   (cpu_data),
        .host_sel   (host_sel),
        .host_we    (host_we),
        .host_addr  (host_addr),
        .host_wdata (host_wdata),
        .host_rdata (host_rdata),
        .wr_count   (wr_count),
        .proto_err  (proto_err),
        .wr_phase   (wr_phase)
    );

    always #5 clk = ~clk;

    typedef struct {
        string      tag;
        logic [3:0] val;
    } exp_t;

    exp_t       exp_q[$];
    exp_t       e;
    logic [3:0] model [128];
    logic [7:0] exp_wr;
    int         n_tests = 0;
    int         n_fail  = 0;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic push_exp(input string tag, input logic [3:0] val);
        exp_q.push_back('{tag, val});
    endtask

    task automatic host_write(input logic [6:0] a, input logic [3:0] d);
        host_sel   = 1'b1;
        host_we    = 1'b1;
        host_addr  = a;
        host_wdata = d;
        step();
        host_we  = 1'b0;
        model[a] = d;
    endtask

    task automatic do_reset();
        rst_p    = 1'b1;
        cpu_wcyc = 1'b0;
        host_sel = 1'b0;
        host_we  = 1'b0;
        step();
        rst_p = 1'b0;
        foreach (model[i]) model[i] = 4'h0;
        exp_wr = 8'd0;
    endtask

    task automatic test_reset();
        rst_p = 1'b1;
        step();
        cpu_bus = 7'h13;
        push_exp("reset_read", 4'h0);
        @(negedge clk);
        e = exp_q.pop_front();
        n_tests++;
        if (cpu_data !== e.val) begin
            n_fail++;
            $display("FAIL %s: cpu_data=%h expected %h", e.tag, cpu_data, e.val);
        end
        n_tests++;
        if ({wr_count, proto_err, wr_phase} !== 10'd0) begin
            n_fail++;
            $display("FAIL reset_status: wr_count=%h proto_err=%b wr_phase=%b expected 0/0/0",
                     wr_count, proto_err, wr_phase);
        end
        step();
        rst_p = 1'b0;
    endtask

    task automatic test_preload();
        host_write(7'h00, 4'hC);
        host_write(7'h01, 4'h0);
        host_write(7'h02, 4'h5);
        host_write(7'h03, 4'h8);
        cpu_bus = 7'h02;
        push_exp("nop_while_host", OP_NOP);
        @(negedge clk);
        e = exp_q.pop_front();
        n_tests++;
        if (cpu_data !== e.val) begin
            n_fail++;
            $display("FAIL %s: cpu_data=%h expected %h", e.tag, cpu_data, e.val);
        end
        step();
        host_sel  = 1'b0;
        host_addr = 7'h02;
        cpu_bus   = 7'h02;
        push_exp("preload_read_02", model[7'h02]);
        #1;
        e = exp_q.pop_front();
        n_tests++;
        if (cpu_data !== e.val) begin
            n_fail++;
            $display("FAIL %s: cpu_data=%h expected %h", e.tag, cpu_data, e.val);
        end
        n_tests++;
        if (host_rdata !== 4'h5) begin
            n_fail++;
            $display("FAIL preload_host_rdata: host_rdata=%h expected 5", host_rdata);
        end
        step();
        cpu_bus = 7'h00;
        push_exp("preload_read_00", model[7'h00]);
        @(negedge clk);
        e = exp_q.pop_front();
        n_tests++;
        if (cpu_data !== e.val) begin
            n_fail++;
            $display("FAIL %s: cpu_data=%h expected %h", e.tag, cpu_data, e.val);
        end
    endtask

    task automatic test_cpu_write();
        step();
        cpu_wcyc = 1'b1;
        cpu_bus  = 7'h2A;
        push_exp("addr_beat_read", model[7'h2A]);
        @(negedge clk);
        e = exp_q.pop_front();
        n_tests++;
        if (cpu_data !== e.val) begin
            n_fail++;
            $display("FAIL %s: cpu_data=%h expected %h", e.tag, cpu_data, e.val);
        end
        step();
        cpu_bus   = 7'h09;
        host_addr = 7'h2A;
        @(negedge clk);
        n_tests++;
        if (host_rdata !== 4'h0 || wr_phase !== 1'b1) begin
            n_fail++;
            $display("FAIL data_beat_old_value: host_rdata=%h wr_phase=%b expected 0/1",
                     host_rdata, wr_phase);
        end
        step();
        model[7'h2A] = 4'h9;
        exp_wr       = exp_wr + 8'd1;
        cpu_wcyc     = 1'b0;
        cpu_bus      = 7'h2A;
        push_exp("write_visible", model[7'h2A]);
        @(negedge clk);
        e = exp_q.pop_front();
        n_tests++;
        if (cpu_data !== e.val) begin
            n_fail++;
            $display("FAIL %s: cpu_data=%h expected %h", e.tag, cpu_data, e.val);
        end
        n_tests++;
        if (wr_count !== exp_wr || proto_err !== 1'b0 || wr_phase !== 1'b0) begin
            n_fail++;
            $display("FAIL write_status: wr_count=%h proto_err=%b wr_phase=%b expected %h/0/0",
                     wr_count, proto_err, wr_phase, exp_wr);
        end
    endtask

    task automatic test_abort();
        step();
        cpu_wcyc = 1'b1;
        cpu_bus  = 7'h10;
        step();
        cpu_wcyc = 1'b0;
        step();
        push_exp("abort_no_write", model[7'h10]);
        @(negedge clk);
        e = exp_q.pop_front();
        n_tests++;
        if (cpu_data !== e.val) begin
            n_fail++;
            $display("FAIL %s: cpu_data=%h expected %h", e.tag, cpu_data, e.val);
        end
        n_tests++;
        if (proto_err !== 1'b1 || wr_count !== exp_wr) begin
            n_fail++;
            $display("FAIL abort_status: proto_err=%b wr_count=%h expected 1/%h",
                     proto_err, wr_count, exp_wr);
        end
        repeat (4) step();
        n_tests++;
        if (proto_err !== 1'b1) begin
            n_fail++;
            $display("FAIL abort_sticky: proto_err=%b expected 1", proto_err);
        end
    endtask

    task automatic test_bad_data();
        do_reset();
        cpu_wcyc = 1'b1;
        cpu_bus  = 7'h11;
        step();
        cpu_bus = 7'h75;
        step();
        model[7'h11] = 4'h5;
        exp_wr       = exp_wr + 8'd1;
        cpu_wcyc     = 1'b0;
        cpu_bus      = 7'h11;
        push_exp("bad_data_written", model[7'h11]);
        @(negedge clk);
        e = exp_q.pop_front();
        n_tests++;
        if (cpu_data !== e.val) begin
            n_fail++;
            $display("FAIL %s: cpu_data=%h expected %h", e.tag, cpu_data, e.val);
        end
        n_tests++;
        if (proto_err !== 1'b1 || wr_count !== exp_wr) begin
            n_fail++;
            $display("FAIL bad_data_status: proto_err=%b wr_count=%h expected 1/%h",
                     proto_err, wr_count, exp_wr);
        end
    endtask

    task automatic test_host_takeover();
        do_reset();
        cpu_wcyc = 1'b1;
        cpu_bus  = 7'h20;
        step();
        host_sel = 1'b1;
        cpu_bus  = 7'h06;
        push_exp("takeover_nop", OP_NOP);
        @(negedge clk);
        e = exp_q.pop_front();
        n_tests++;
        if (cpu_data !== e.val) begin
            n_fail++;
            $display("FAIL %s: cpu_data=%h expected %h", e.tag, cpu_data, e.val);
        end
        step();
        host_sel = 1'b0;
        cpu_wcyc = 1'b0;
        cpu_bus  = 7'h20;
        push_exp("takeover_no_write", model[7'h20]);
        @(negedge clk);
        e = exp_q.pop_front();
        n_tests++;
        if (cpu_data !== e.val) begin
            n_fail++;
            $display("FAIL %s: cpu_data=%h expected %h", e.tag, cpu_data, e.val);
        end
        n_tests++;
        if (proto_err !== 1'b0 || wr_count !== exp_wr || wr_phase !== 1'b0) begin
            n_fail++;
            $display("FAIL takeover_status: proto_err=%b wr_count=%h wr_phase=%b expected 0/%h/0",
                     proto_err, wr_count, wr_phase, exp_wr);
        end
    endtask

    task automatic test_back_to_back_wrap();
        do_reset();
        for (int i = 0; i < 256; i++) begin
            step();
            cpu_wcyc = 1'b1;
            cpu_bus  = 7'(i);
            if (i == 255) begin
                @(negedge clk);
                n_tests++;
                if (wr_count !== 8'd255) begin
                    n_fail++;
                    $display("FAIL wrap_255: wr_count=%h expected ff", wr_count);
                end
            end
            step();
            cpu_bus          = {3'b000, 4'(i * 3)};
            model[7'(i)]     = 4'(i * 3);
            exp_wr           = exp_wr + 8'd1;
        end
        step();
        cpu_wcyc = 1'b0;
        cpu_bus  = 7'h33;
        push_exp("wrap_read_33", model[7'h33]);
        @(negedge clk);
        e = exp_q.pop_front();
        n_tests++;
        if (cpu_data !== e.val) begin
            n_fail++;
            $display("FAIL %s: cpu_data=%h expected %h", e.tag, cpu_data, e.val);
        end
        n_tests++;
        if (wr_count !== exp_wr || wr_count !== 8'd0 || proto_err !== 1'b0) begin
            n_fail++;
            $display("FAIL wrap_zero: wr_count=%h proto_err=%b expected 00/0", wr_count, proto_err);
        end
    endtask

    // CPU emulation: STA 0x40 (reg_a=3) then LDB 0x40; slow mode holds each fetch two cycles
    task automatic test_program(input bit fast);
        logic [6:0] rd [7];
        int         hold;
        rd   = '{7'h00, 7'h01, 7'h02, 7'h03, 7'h04, 7'h05, 7'h40};
        hold = fast ? 1 : 2;
        host_write(7'h00, OP_STA);
        host_write(7'h01, 4'h4);
        host_write(7'h02, 4'h0);
        host_write(7'h03, OP_LDB);
        host_write(7'h04, 4'h4);
        host_write(7'h05, 4'h0);
        host_write(7'h40, 4'h0);
        host_sel = 1'b0;
        for (int i = 0; i < 7; i++) begin
            if (i == 3) begin
                step();
                cpu_wcyc = 1'b1;
                cpu_bus  = 7'h40;
                step();
                cpu_bus = 7'h03;
                step();
                model[7'h40] = 4'h3;
                exp_wr       = exp_wr + 8'd1;
                cpu_wcyc     = 1'b0;
                cpu_bus      = rd[i];
            end else begin
                step();
                cpu_wcyc = 1'b0;
                cpu_bus  = rd[i];
            end
            for (int h = 0; h < hold; h++) begin
                if (h > 0) step();
                push_exp(fast ? "prog_fast_read" : "prog_slow_read", model[rd[i]]);
                @(negedge clk);
                e = exp_q.pop_front();
                n_tests++;
                if (cpu_data !== e.val) begin
                    n_fail++;
                    $display("FAIL %s: addr=%h cpu_data=%h expected %h", e.tag, rd[i], cpu_data, e.val);
                end
            end
        end
        host_addr = 7'h40;
        #1;
        n_tests++;
        if (host_rdata !== 4'h3 || wr_count !== exp_wr) begin
            n_fail++;
            $display("FAIL prog_mem40: host_rdata=%h wr_count=%h expected 3/%h",
                     host_rdata, wr_count, exp_wr);
        end
    endtask

    task automatic test_reset_mid_write();
        do_reset();
        cpu_wcyc = 1'b1;
        cpu_bus  = 7'h05;
        step();
        rst_p = 1'b1;
        #1;
        n_tests++;
        if (wr_phase !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_mid_write_phase: wr_phase=%b expected 0", wr_phase);
        end
        rst_p   = 1'b0;
        cpu_bus = 7'h07;
        step();
        cpu_bus = 7'h03;
        @(negedge clk);
        n_tests++;
        if (wr_phase !== 1'b1) begin
            n_fail++;
            $display("FAIL reset_mid_write_rearm: wr_phase=%b expected 1", wr_phase);
        end
        step();
        model[7'h07] = 4'h3;
        exp_wr       = exp_wr + 8'd1;
        cpu_wcyc     = 1'b0;
        cpu_bus      = 7'h05;
        push_exp("reset_mid_write_05", model[7'h05]);
        @(negedge clk);
        e = exp_q.pop_front();
        n_tests++;
        if (cpu_data !== e.val) begin
            n_fail++;
            $display("FAIL %s: cpu_data=%h expected %h", e.tag, cpu_data, e.val);
        end
        step();
        cpu_bus = 7'h07;
        push_exp("reset_mid_write_07", model[7'h07]);
        @(negedge clk);
        e = exp_q.pop_front();
        n_tests++;
        if (cpu_data !== e.val || wr_count !== exp_wr) begin
            n_fail++;
            $display("FAIL %s: cpu_data=%h wr_count=%h expected %h/%h",
                     e.tag, cpu_data, wr_count, e.val, exp_wr);
        end
    endtask

    initial begin
        rst_p      = 1'b1;
        cpu_bus    = '0;
        cpu_wcyc   = 1'b0;
        host_sel   = 1'b0;
        host_we    = 1'b0;
        host_addr  = '0;
        host_wdata = '0;
        exp_wr     = 8'd0;
        foreach (model[i]) model[i] = 4'h0;

        test_reset();
        test_preload();
        test_cpu_write();
        test_abort();
        test_bad_data();
        test_host_takeover();
        test_back_to_back_wrap();
        do_reset();
        test_program(1'b0);
        test_program(1'b1);
        test_reset_mid_write();

        n_tests++;
        if (exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL scoreboard_drain: %0d entries left expected 0", exp_q.size());
        end
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

endmodule
